// File: rtl/jfpjc_pkg.sv
// Shared types and constants for the JFIF stream sequencer.
package jfpjc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    BODY,
    EOI_FF,
    EOI_D9
  } state_t;

  localparam logic [7:0] JPEG_MARKER        = 8'hFF;
  localparam logic [7:0] EOI_CODE           = 8'hD9;
  localparam logic [7:0] STUFF_BYTE         = 8'h00;
  localparam int         DEFAULT_HEADER_LEN = 328;

endpackage

// File: rtl/jss_byte_fifo.sv
// Byte FIFO between the entropy coder and the output sequencer.
// A push while full is accepted only when a pop happens in the same cycle.
module jss_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]     mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; the extra MSB tells full from empty.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; emptiness is tracked by the pointers, so stale contents are never read.
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/jpeg_stream_sequencer.sv
// Builds one JFIF byte stream per frame: ROM header, stuffed entropy bytes, EOI.
module jpeg_stream_sequencer
  import jfpjc_pkg::*;
#(
  parameter int HEADER_LEN = DEFAULT_HEADER_LEN,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 9
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              frame_start,
  input  logic              entropy_valid,
  input  logic [7:0]        entropy_data,
  input  logic              entropy_done,
  output logic [ADDR_W-1:0] header_addr,
  input  logic [7:0]        header_data,
  output logic [7:0]        data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overflow,
  output logic              frame_overrun
);

  state_t            state;
  logic [ADDR_W-1:0] rd_idx;         // header byte currently presented by the ROM
  logic              stuff_pending;
  logic              done_seen;

  logic              can_load;
  logic              hdr_load;
  logic              hdr_last;
  logic              fifo_pop;
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  // The output register may take a new byte when empty or when its byte leaves now.
  assign can_load = !data_valid || data_ready;
  assign hdr_load = (state == HEADER) && can_load;
  assign hdr_last = (rd_idx == ADDR_W'(HEADER_LEN - 1));
  assign fifo_pop = (state == BODY) && can_load && !stuff_pending && !fifo_empty;
  assign busy     = (state != IDLE);

  // The address steps ahead only when the current ROM byte is consumed, so a
  // stall keeps the ROM output on the byte still to be loaded. Wraps to 0 after
  // the last byte so the ROM already presents byte 0 for the next frame.
  assign header_addr = !hdr_load ? rd_idx
                     : (hdr_last ? '0 : rd_idx + 1'b1);

  jss_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .nreset    (nreset),
    .push      (entropy_valid),
    .push_data (entropy_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame FSM with output register, header index and sticky status flags.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state         <= IDLE;
      rd_idx        <= '0;
      stuff_pending <= 1'b0;
      done_seen     <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      overflow      <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      if (entropy_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (frame_start && state != IDLE)           frame_overrun <= 1'b1;
      if (entropy_done && (state == HEADER || state == BODY)) done_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state  <= HEADER;
            rd_idx <= '0;
          end
        end

        // BODY is entered once the last header byte sits in the output
        // register; popping still waits for that byte's transfer.
        HEADER: begin
          if (can_load) begin
            data_out   <= header_data;
            data_valid <= 1'b1;
            if (hdr_last) begin
              rd_idx <= '0;
              state  <= BODY;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end

        BODY: begin
          if (can_load) begin
            if (stuff_pending) begin
              data_out      <= STUFF_BYTE;
              data_valid    <= 1'b1;
              stuff_pending <= 1'b0;
            end else if (!fifo_empty) begin
              data_out      <= fifo_head;
              data_valid    <= 1'b1;
              stuff_pending <= (fifo_head == JPEG_MARKER);
            end else begin
              data_valid <= 1'b0;
              if (done_seen) state <= EOI_FF;
            end
          end
        end

        EOI_FF: begin
          if (can_load) begin
            data_out   <= JPEG_MARKER;
            data_valid <= 1'b1;
            state      <= EOI_D9;
          end
        end

        // Loads D9 behind the FF, then returns to IDLE on the D9 transfer.
        EOI_D9: begin
          if (data_valid && data_out == EOI_CODE) begin
            if (data_ready) begin
              data_valid <= 1'b0;
              done_seen  <= 1'b0;
              state      <= IDLE;
            end
          end else if (can_load) begin
            data_out   <= EOI_CODE;
            data_valid <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
